npu_spi_master: RTL and testbench
=================================

NPU_SPI_MASTER -- requirements
Module: npu_spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning clk_100M cycles per SCLK half-period (legal range 2..255), giving SCLK 12.5 MHz at the default.
REQ-002 SHALL have parameter CS_SETUP_CYC, default 2, meaning clk_100M cycles from cs_n falling to the first SCLK half-period.
REQ-003 SHALL have parameter CS_HOLD_CYC, default 2, meaning clk_100M cycles from the last SCLK falling edge to cs_n rising.
REQ-004 SHALL have port clk_100M  in  1  system clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port tx_data  in  8  byte to transmit.
REQ-007 SHALL have port tx_valid  in  1  tx_data valid.
REQ-008 SHALL have port tx_last  in  1  byte is the last of the transaction; qualified by tx_valid.
REQ-009 SHALL have port tx_ready  out  1  controller accepts a byte this cycle.
REQ-010 SHALL have port rx_data  out  8  byte received on miso.
REQ-011 SHALL have port rx_valid  out  1  one-cycle pulse; rx_data valid.
REQ-012 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-013 SHALL have ports sclk  out  1; mosi  out  1; cs_n  out  1; miso  in  1 (SPI mode 0, MSB first).

Function
REQ-014 SHALL use FSM states IDLE, SETUP, SHIFT, NEXT and HOLD.
REQ-015 A byte SHALL transfer on any cycle with tx_valid and tx_ready both high; tx_ready SHALL be high only in IDLE and NEXT.
REQ-016 From IDLE, on transfer: latch tx_data and tx_last; cs_n low next cycle; go to SETUP for CS_SETUP_CYC cycles, then SHIFT.
REQ-017 SHIFT: 8 bits, each 2*CLK_DIV cycles; sclk low for the first CLK_DIV cycles, high for the next CLK_DIV.
REQ-018 mosi SHALL take the current bit (MSB first) on the first cycle of each bit's low phase and hold it for the whole bit.
REQ-019 miso SHALL be captured into the rx shift register on the last cycle of each high phase, before sclk falls.
REQ-020 After bit 7: rx_data updated and rx_valid pulsed for exactly one cycle; sclk returns low.
REQ-021 After bit 7, latched tx_last=0 -> NEXT; tx_last=1 -> HOLD.
REQ-022 NEXT: cs_n stays low, sclk low, mosi held; waits indefinitely for a transfer; on transfer, latch the byte and enter SHIFT next cycle with no extra setup.
REQ-023 HOLD: CS_HOLD_CYC cycles, then cs_n high and IDLE; tx_ready stays low during HOLD.
REQ-024 IDLE: cs_n=1, sclk=0, mosi=0, tx_ready=1.
REQ-025 Total cs_n-low time for one single-byte transaction SHALL be CS_SETUP_CYC + 16*CLK_DIV + CS_HOLD_CYC cycles.
REQ-026 tx_valid while tx_ready=0 SHALL be ignored; the source must hold it (valid/ready semantics).
REQ-027 The half-period counter and bit counter SHALL be unsigned, sized for CLK_DIV-1 and 7 respectively, and reset to 0 at each state entry.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, cs_n=1, sclk=0, mosi=0, tx_ready=0, rx_valid=0, rx_data=0x00, busy=0, and all counters to 0.
REQ-029 tx_ready SHALL rise on the first clk_100M edge after rst_n deasserts.
REQ-030 Reset mid-transaction SHALL abort it without emitting rx_valid; the partial byte is discarded.

Structure
REQ-031 Package npu_spi_pkg SHALL hold the FSM state enum, default CLK_DIV/CS_SETUP_CYC/CS_HOLD_CYC, and the SPI word width constant (8).
REQ-032 Sub-module npu_spi_sclk_gen SHALL generate the half-period tick and sclk phase; the FSM and shift registers live in npu_spi_master.

Verification
REQ-033 Loopback (miso=mosi), CLK_DIV=4: send 0xA5 with tx_last=1 -> rx_data=0xA5 with one rx_valid pulse; cs_n low for exactly 68 cycles.
REQ-034 Slave model returns 0x3C while master sends 0x00 -> rx_data=0x3C; mosi stays 0 throughout; 8 sclk rising edges.
REQ-035 Three bytes 0x01,0x02,0x03 (last on 0x03), back-to-back -> cs_n low continuously, 24 sclk pulses, three rx_valid pulses.
REQ-036 Second byte tx_valid delayed 50 cycles -> controller sits in NEXT, cs_n low, sclk low; resumes correctly.
REQ-037 rst_n asserted mid-bit 4 -> cs_n=1 and sclk=0 asynchronously; no rx_valid; next transaction is correct.
REQ-038 CLK_DIV=2 -> each sclk half-period is exactly 2 cycles; mosi is stable across every sclk rising edge.

Source files
------------

// File: rtl/npu_spi_pkg.sv
// Shared definitions for the NPU SPI master: controller states, default timing
// parameters and the word width.
package npu_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    NEXT,
    HOLD
  } spiState_e;

  localparam int unsigned DEF_CLK_DIV      = 4;
  localparam int unsigned DEF_CS_SETUP_CYC = 2;
  localparam int unsigned DEF_CS_HOLD_CYC  = 2;
  localparam int unsigned SPI_WORD_W       = 8;

  // Bits needed for a counter running 0..n-1 (at least one bit).
  function automatic int unsigned cntWidth(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/npu_spi_sclk_gen.sv
// SPI clock generator: CLK_DIV system cycles per half-period while enabled,
// flagging the last cycle of each high phase, where a bit completes.
module npu_spi_sclk_gen
  import npu_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk_100M,
  input  logic rst_n,
  input  logic en_i,
  output logic sclk_o,
  output logic bitEnd_o
);

  localparam int unsigned HALF_W = cntWidth(CLK_DIV);

  logic [HALF_W-1:0] halfCnt_q, halfCnt_d;
  logic              phase_q, phase_d;
  logic              halfDone;

  assign halfDone = (halfCnt_q == HALF_W'(CLK_DIV - 1));

  // Counter and phase collapse to zero whenever disabled, so every enable starts a low phase.
  always_comb begin
    halfCnt_d = '0;
    phase_d   = 1'b0;
    if (en_i) begin
      if (halfDone) begin
        halfCnt_d = '0;
        phase_d   = ~phase_q;
      end else begin
        halfCnt_d = halfCnt_q + 1'b1;
        phase_d   = phase_q;
      end
    end
  end

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      halfCnt_q <= '0;
      phase_q   <= 1'b0;
    end else begin
      halfCnt_q <= halfCnt_d;
      phase_q   <= phase_d;
    end
  end

  assign sclk_o   = phase_q;
  assign bitEnd_o = en_i & phase_q & halfDone;

endmodule

// File: rtl/npu_spi_master.sv
// SPI mode-0 master, MSB first, with a valid/ready byte stream; cs_n spans a whole
// multi-byte transaction and is released only after the byte flagged last.
module npu_spi_master
  import npu_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV      = DEF_CLK_DIV,
  parameter int unsigned CS_SETUP_CYC = DEF_CS_SETUP_CYC,
  parameter int unsigned CS_HOLD_CYC  = DEF_CS_HOLD_CYC
) (
  input  logic                  clk_100M,
  input  logic                  rst_n,
  input  logic [SPI_WORD_W-1:0] tx_data,
  input  logic                  tx_valid,
  input  logic                  tx_last,
  output logic                  tx_ready,
  output logic [SPI_WORD_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  cs_n,
  input  logic                  miso
);

  localparam int unsigned DLY_MAX = (CS_SETUP_CYC > CS_HOLD_CYC) ? CS_SETUP_CYC : CS_HOLD_CYC;
  localparam int unsigned DLY_W   = cntWidth(DLY_MAX);
  localparam int unsigned BIT_W   = cntWidth(SPI_WORD_W);

  spiState_e             state_q, state_d;
  logic [DLY_W-1:0]      cycCnt_q, cycCnt_d;
  logic [BIT_W-1:0]      bitCnt_q, bitCnt_d;
  logic [SPI_WORD_W-1:0] txShift_q, txShift_d;
  logic [SPI_WORD_W-1:0] rxShift_q, rxShift_d;
  logic [SPI_WORD_W-1:0] rxData_q, rxData_d;
  logic                  rxValid_q, rxValid_d;
  logic                  mosi_q, mosi_d;
  logic                  last_q, last_d;
  logic                  readyEn_q;
  logic                  bitEnd;
  logic                  transfer;

  npu_spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk_100M (clk_100M),
    .rst_n    (rst_n),
    .en_i     (state_q == SHIFT),
    .sclk_o   (sclk),
    .bitEnd_o (bitEnd)
  );

  // Holds tx_ready low through reset and releases it on the first edge afterwards.
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) readyEn_q <= 1'b0;
    else        readyEn_q <= 1'b1;
  end

  assign tx_ready = readyEn_q && ((state_q == IDLE) || (state_q == NEXT));
  assign transfer = tx_valid && tx_ready;

  always_comb begin
    state_d   = state_q;
    cycCnt_d  = '0;
    bitCnt_d  = bitCnt_q;
    txShift_d = txShift_q;
    rxShift_d = rxShift_q;
    rxData_d  = rxData_q;
    rxValid_d = 1'b0;
    mosi_d    = mosi_q;
    last_d    = last_q;
    unique case (state_q)
      IDLE: begin
        mosi_d   = 1'b0;
        bitCnt_d = '0;
        if (transfer) begin
          txShift_d = tx_data;
          last_d    = tx_last;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (cycCnt_q == DLY_W'(CS_SETUP_CYC - 1)) begin
          mosi_d    = txShift_q[SPI_WORD_W-1];
          txShift_d = {txShift_q[SPI_WORD_W-2:0], 1'b0};
          bitCnt_d  = '0;
          state_d   = SHIFT;
        end else begin
          cycCnt_d = cycCnt_q + 1'b1;
        end
      end
      // mosi moves to the next bit on the same edge that sclk falls.
      SHIFT: begin
        if (bitEnd) begin
          rxShift_d = {rxShift_q[SPI_WORD_W-2:0], miso};
          if (bitCnt_q == BIT_W'(SPI_WORD_W - 1)) begin
            rxData_d  = {rxShift_q[SPI_WORD_W-2:0], miso};
            rxValid_d = 1'b1;
            bitCnt_d  = '0;
            state_d   = last_q ? HOLD : NEXT;
          end else begin
            bitCnt_d  = bitCnt_q + 1'b1;
            mosi_d    = txShift_q[SPI_WORD_W-1];
            txShift_d = {txShift_q[SPI_WORD_W-2:0], 1'b0};
          end
        end
      end
      NEXT: begin
        if (transfer) begin
          last_d    = tx_last;
          mosi_d    = tx_data[SPI_WORD_W-1];
          txShift_d = {tx_data[SPI_WORD_W-2:0], 1'b0};
          bitCnt_d  = '0;
          state_d   = SHIFT;
        end
      end
      HOLD: begin
        if (cycCnt_q == DLY_W'(CS_HOLD_CYC - 1)) begin
          mosi_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cycCnt_d = cycCnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cycCnt_q  <= '0;
      bitCnt_q  <= '0;
      txShift_q <= '0;
      rxShift_q <= '0;
      rxData_q  <= '0;
      rxValid_q <= 1'b0;
      mosi_q    <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cycCnt_q  <= cycCnt_d;
      bitCnt_q  <= bitCnt_d;
      txShift_q <= txShift_d;
      rxShift_q <= rxShift_d;
      rxData_q  <= rxData_d;
      rxValid_q <= rxValid_d;
      mosi_q    <= mosi_d;
      last_q    <= last_d;
    end
  end

  assign cs_n     = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign mosi     = mosi_q;
  assign rx_data  = rxData_q;
  assign rx_valid = rxValid_q;

endmodule

// File: tb/tb_npu_spi_master.sv
// Bench for npu_spi_master: one instance at the default divider with loopback or a
// rotating-byte slave, and one at CLK_DIV=2 for minimum half-period timing.
module tb_npu_spi_master;

  localparam int DIV_A   = 4;
  localparam int SETUP_A = 2;
  localparam int HOLD_A  = 2;
  localparam int DIV_B   = 2;

  logic clk_100M = 1'b0;
  logic rst_n    = 1'b1;

  always #5 clk_100M = ~clk_100M;

  logic [7:0] txDataA, rxDataA, txDataB, rxDataB;
  logic txValidA, txLastA, txReadyA, rxValidA, busyA, sclkA, mosiA, csNA, misoA;
  logic txValidB, txLastB, txReadyB, rxValidB, busyB, sclkB, mosiB, csNB, misoB;

  logic       loopA     = 1'b1;
  logic [7:0] slaveByte = 8'h00;
  logic [2:0] slaveBitA = 3'd0;

  assign misoA = loopA ? mosiA : slaveByte[~slaveBitA];
  assign misoB = mosiB;

  npu_spi_master #(.CLK_DIV(DIV_A), .CS_SETUP_CYC(SETUP_A), .CS_HOLD_CYC(HOLD_A)) dutA (
    .clk_100M(clk_100M), .rst_n(rst_n), .tx_data(txDataA), .tx_valid(txValidA),
    .tx_last(txLastA), .tx_ready(txReadyA), .rx_data(rxDataA), .rx_valid(rxValidA),
    .busy(busyA), .sclk(sclkA), .mosi(mosiA), .cs_n(csNA), .miso(misoA));

  npu_spi_master #(.CLK_DIV(DIV_B), .CS_SETUP_CYC(SETUP_A), .CS_HOLD_CYC(HOLD_A)) dutB (
    .clk_100M(clk_100M), .rst_n(rst_n), .tx_data(txDataB), .tx_valid(txValidB),
    .tx_last(txLastB), .tx_ready(txReadyB), .rx_data(rxDataB), .rx_valid(rxValidB),
    .busy(busyB), .sclk(sclkB), .mosi(mosiB), .cs_n(csNB), .miso(misoB));

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor A: line statistics sampled mid-cycle, plus the slave's bit pointer.
  int   cycA = 0, csLowA = 0, csRiseA = 0, risesA = 0, lastRiseA = 0, hiRunA = 0;
  int   riseInByteA = 0, stabErrA = 0, periodErrA = 0, pulseErrA = 0, idleErrA = 0;
  logic sclkPrevA, mosiPrevA, csPrevA, rxvPrevA;
  logic [7:0] rxQA[$];
  logic       mosiQA[$];

  always @(negedge clk_100M) begin
    cycA <= cycA + 1;
    if (!rst_n) begin
      sclkPrevA <= 1'b0; mosiPrevA <= 1'b0; csPrevA <= 1'b1; rxvPrevA <= 1'b0;
      hiRunA <= 0; riseInByteA <= 0; slaveBitA <= 3'd0;
    end else begin
      if (!csNA) csLowA <= csLowA + 1;
      if (csNA && !csPrevA) csRiseA <= csRiseA + 1;
      if (csNA && (sclkA || mosiA)) idleErrA <= idleErrA + 1;
      if (sclkA && !sclkPrevA) begin
        mosiQA.push_back(mosiA);
        if (mosiA !== mosiPrevA) stabErrA <= stabErrA + 1;
        if (riseInByteA != 0 && (cycA - lastRiseA) != 2 * DIV_A) periodErrA <= periodErrA + 1;
        lastRiseA   <= cycA;
        riseInByteA <= (riseInByteA == 7) ? 0 : riseInByteA + 1;
        risesA      <= risesA + 1;
      end
      if (sclkA) hiRunA <= hiRunA + 1;
      else begin
        if (sclkPrevA && hiRunA != DIV_A) periodErrA <= periodErrA + 1;
        hiRunA <= 0;
      end
      if (rxValidA) begin
        rxQA.push_back(rxDataA);
        if (rxvPrevA) pulseErrA <= pulseErrA + 1;
      end
      if (csNA) slaveBitA <= 3'd0;
      else if (sclkPrevA && !sclkA) slaveBitA <= slaveBitA + 3'd1;
      sclkPrevA <= sclkA; mosiPrevA <= mosiA; csPrevA <= csNA; rxvPrevA <= rxValidA;
    end
  end

  // Monitor B: half-period timing and mosi stability at the fastest divider.
  int   cycB = 0, csLowB = 0, risesB = 0, lastRiseB = 0, hiRunB = 0, riseInByteB = 0;
  int   stabErrB = 0, periodErrB = 0;
  logic sclkPrevB, mosiPrevB;

  always @(negedge clk_100M) begin
    cycB <= cycB + 1;
    if (!rst_n) begin
      sclkPrevB <= 1'b0; mosiPrevB <= 1'b0; hiRunB <= 0; riseInByteB <= 0;
    end else begin
      if (!csNB) csLowB <= csLowB + 1;
      if (sclkB && !sclkPrevB) begin
        if (mosiB !== mosiPrevB) stabErrB <= stabErrB + 1;
        if (riseInByteB != 0 && (cycB - lastRiseB) != 2 * DIV_B) periodErrB <= periodErrB + 1;
        lastRiseB   <= cycB;
        riseInByteB <= (riseInByteB == 7) ? 0 : riseInByteB + 1;
        risesB      <= risesB + 1;
      end
      if (sclkB) hiRunB <= hiRunB + 1;
      else begin
        if (sclkPrevB && hiRunB != DIV_B) periodErrB <= periodErrB + 1;
        hiRunB <= 0;
      end
      sclkPrevB <= sclkB; mosiPrevB <= mosiB;
    end
  end

  logic [7:0] txBytes[8];
  int         gaps[8];
  int         numBytes;

  task automatic sendByteA(input logic [7:0] d, input logic l);
    int budget;
    budget   = 0;
    txDataA  = d;
    txLastA  = l;
    txValidA = 1'b1;
    while (!txReadyA && budget < 2000) begin
      @(negedge clk_100M);
      budget++;
    end
    checkOutput("handshakeA", {31'd0, txReadyA}, 32'd1);
    @(negedge clk_100M);
    txValidA = 1'b0;
    txDataA  = 8'($urandom);
    txLastA  = 1'($urandom);
  endtask

  // One transaction of numBytes bytes; expectations come from the byte list and timing rules.
  task automatic applyStimulus();
    int csLow0, csRise0, rises0, rx0, mb0, stab0, period0, pulse0, idle0;
    int expLow, budget;
    logic [7:0] b;
    csLow0 = csLowA; csRise0 = csRiseA; rises0 = risesA; rx0 = rxQA.size();
    mb0 = mosiQA.size(); stab0 = stabErrA; period0 = periodErrA; pulse0 = pulseErrA;
    idle0 = idleErrA;
    expLow = SETUP_A + HOLD_A + 16 * DIV_A * numBytes;
    for (int i = 0; i < numBytes; i++) begin
      if (i > 0) begin
        expLow += 1 + gaps[i];
        if (gaps[i] > 0) begin
          budget = 0;
          do begin
            @(negedge clk_100M);
            budget++;
          end while (!rxValidA && budget < 2000);
          checkOutput("byteDoneA", {31'd0, rxValidA}, 32'd1);
          repeat (gaps[i] / 2) @(negedge clk_100M);
          checkOutput("nextCsN", {31'd0, csNA}, 32'd0);
          checkOutput("nextSclk", {31'd0, sclkA}, 32'd0);
          checkOutput("nextBusy", {31'd0, busyA}, 32'd1);
          checkOutput("nextReady", {31'd0, txReadyA}, 32'd1);
          repeat (gaps[i] - gaps[i] / 2) @(negedge clk_100M);
        end
      end
      sendByteA(txBytes[i], (i == numBytes - 1));
    end
    budget = 0;
    while (!csNA && budget < 5000) begin
      @(negedge clk_100M);
      budget++;
    end
    checkOutput("csReleaseA", {31'd0, csNA}, 32'd1);
    @(negedge clk_100M);
    @(negedge clk_100M);
    checkOutput("csLowCycles", csLowA - csLow0, expLow);
    checkOutput("csContiguous", csRiseA - csRise0, 1);
    checkOutput("sclkRises", risesA - rises0, 8 * numBytes);
    checkOutput("rxCount", rxQA.size() - rx0, numBytes);
    for (int i = 0; i < numBytes; i++) begin
      if (rx0 + i < rxQA.size())
        checkOutput("rxByte", rxQA[rx0 + i], loopA ? txBytes[i] : slaveByte);
      if (mb0 + 8 * i + 7 < mosiQA.size()) begin
        b = 8'h00;
        for (int j = 0; j < 8; j++) b = {b[6:0], mosiQA[mb0 + 8 * i + j]};
        checkOutput("mosiByte", b, txBytes[i]);
      end
    end
    checkOutput("mosiStable", stabErrA - stab0, 0);
    checkOutput("sclkTiming", periodErrA - period0, 0);
    checkOutput("rxPulse", pulseErrA - pulse0, 0);
    checkOutput("idleLines", idleErrA - idle0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog simulation did not complete");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int budget, rx0, r0, csLowB0, risesB0, stabB0, periodB0;
    logic [7:0] d;
    txDataA = 8'h00; txValidA = 1'b0; txLastA = 1'b0;
    txDataB = 8'h00; txValidB = 1'b0; txLastB = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstCsN", {31'd0, csNA}, 32'd1);
    checkOutput("rstSclk", {31'd0, sclkA}, 32'd0);
    checkOutput("rstMosi", {31'd0, mosiA}, 32'd0);
    checkOutput("rstReady", {31'd0, txReadyA}, 32'd0);
    checkOutput("rstRxValid", {31'd0, rxValidA}, 32'd0);
    checkOutput("rstRxData", {24'd0, rxDataA}, 32'd0);
    checkOutput("rstBusy", {31'd0, busyA}, 32'd0);
    repeat (3) @(negedge clk_100M);
    checkOutput("rstReadyClocked", {31'd0, txReadyA}, 32'd0);
    rst_n = 1'b1;
    #1 checkOutput("readyBeforeEdge", {31'd0, txReadyA}, 32'd0);
    @(negedge clk_100M);
    checkOutput("readyAfterEdge", {31'd0, txReadyA}, 32'd1);

    $display("[TB] loopback single byte 0xA5");
    loopA = 1'b1; numBytes = 1; txBytes[0] = 8'hA5; gaps[0] = 0;
    applyStimulus();

    $display("[TB] slave returns 0x3C while master sends 0x00");
    loopA = 1'b0; slaveByte = 8'h3C; numBytes = 1; txBytes[0] = 8'h00;
    applyStimulus();

    $display("[TB] three bytes back-to-back");
    loopA = 1'b1; numBytes = 3;
    txBytes[0] = 8'h01; txBytes[1] = 8'h02; txBytes[2] = 8'h03;
    gaps[0] = 0; gaps[1] = 0; gaps[2] = 0;
    applyStimulus();

    $display("[TB] second byte delayed 50 cycles");
    numBytes = 2; txBytes[0] = 8'h5A; txBytes[1] = 8'hC7; gaps[1] = 50;
    applyStimulus();

    $display("[TB] reset during bit 4");
    loopA = 1'b1; rx0 = rxQA.size(); r0 = risesA;
    txDataA = 8'hC3; txLastA = 1'b1; txValidA = 1'b1;
    @(negedge clk_100M);
    txValidA = 1'b0;
    budget = 0;
    while ((risesA - r0) < 5 && budget < 2000) begin
      @(negedge clk_100M);
      budget++;
    end
    checkOutput("reachBit4", risesA - r0, 5);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abortCsN", {31'd0, csNA}, 32'd1);
    checkOutput("abortSclk", {31'd0, sclkA}, 32'd0);
    checkOutput("abortBusy", {31'd0, busyA}, 32'd0);
    checkOutput("abortReady", {31'd0, txReadyA}, 32'd0);
    repeat (4) @(negedge clk_100M);
    rst_n = 1'b1;
    repeat (40) @(negedge clk_100M);
    checkOutput("abortNoRxValid", rxQA.size() - rx0, 0);
    checkOutput("abortRxData", {24'd0, rxDataA}, 32'd0);
    numBytes = 1; txBytes[0] = 8'($urandom);
    applyStimulus();

    $display("[TB] randomized transactions");
    for (int t = 0; t < 8; t++) begin
      numBytes  = $urandom_range(1, 3);
      loopA     = 1'($urandom_range(0, 1));
      slaveByte = 8'($urandom);
      for (int i = 0; i < numBytes; i++) begin
        txBytes[i] = 8'($urandom);
        gaps[i]    = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : 0;
      end
      applyStimulus();
    end

    $display("[TB] CLK_DIV=2 instance");
    csLowB0 = csLowB; risesB0 = risesB; stabB0 = stabErrB; periodB0 = periodErrB;
    for (int k = 0; k < 4; k++) begin
      d = 8'($urandom);
      txDataB = d; txLastB = 1'b1; txValidB = 1'b1;
      budget = 0;
      while (!txReadyB && budget < 2000) begin
        @(negedge clk_100M);
        budget++;
      end
      @(negedge clk_100M);
      txValidB = 1'b0; txDataB = 8'($urandom);
      budget = 0;
      while (!rxValidB && budget < 2000) begin
        @(negedge clk_100M);
        budget++;
      end
      checkOutput("rxByteB", {24'd0, rxDataB}, {24'd0, d});
      budget = 0;
      while (busyB && budget < 2000) begin
        @(negedge clk_100M);
        budget++;
      end
      @(negedge clk_100M);
    end
    checkOutput("csLowCyclesB", csLowB - csLowB0, 4 * (SETUP_A + 16 * DIV_B + HOLD_A));
    checkOutput("sclkRisesB", risesB - risesB0, 32);
    checkOutput("sclkTimingB", periodErrB - periodB0, 0);
    checkOutput("mosiStableB", stabErrB - stabB0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
